// File: rtl/fp_mul_arb_pkg.sv
// Shared constants for the arbiters that front the floating-point units.
package fp_mul_arb_pkg;

  localparam int FP_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts just above the last grant and wraps, so each request
// is granted within NUM_REQ cycles.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    lastIdx_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grantIdx_o,
  output logic               grantValid_o
);

  logic [ID_W-1:0] hiIdx;
  logic            hiFound;
  logic [ID_W-1:0] loIdx;
  logic            loFound;

  // Lowest request strictly above the last grant wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hiIdx   = '0;
    hiFound = 1'b0;
    loIdx   = '0;
    loFound = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        loIdx   = ID_W'(i);
        loFound = 1'b1;
        if (i > int'(lastIdx_i)) begin
          hiIdx   = ID_W'(i);
          hiFound = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grantValid_o = hiFound | loFound;
    grantIdx_o   = hiFound ? hiIdx : loIdx;
    grant_o      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = grantValid_o && (grantIdx_o == ID_W'(i));
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fixed-latency fp_mul pipeline among NUM_REQ requesters. A tag pipeline that matches the
// multiplier latency carries each requester id forward, so every result goes back to the requester that issued it.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 6,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][FP_W-1:0]   req_dataa,
  input  logic [NUM_REQ-1:0][FP_W-1:0]   req_datab,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [FP_W-1:0]                mul_dataa,
  output logic [FP_W-1:0]                mul_datab,
  input  logic [FP_W-1:0]                mul_result,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [FP_W-1:0]                resp_data,
  output logic                           busy
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // One stage per edge from the issue edge through edge k+MUL_LATENCY.
  localparam int DEPTH = MUL_LATENCY + 1;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grantIdx;
  logic               grantValid;

  logic [ID_W-1:0]    rrLast_q, rrLast_d;
  logic [FP_W-1:0]    heldA_q, heldA_d;
  logic [FP_W-1:0]    heldB_q, heldB_d;
  tag_t               tagIn;
  tag_t               tag_q [DEPTH];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i        (req_valid),
    .lastIdx_i    (rrLast_q),
    .grant_o      (grant),
    .grantIdx_o   (grantIdx),
    .grantValid_o (grantValid)
  );

  // Without a winner the multiplier keeps seeing the last issued operands; its output is simply never tagged valid.
  always_comb begin
    rrLast_d = rrLast_q;
    heldA_d  = heldA_q;
    heldB_d  = heldB_q;
    tagIn    = '0;
    if (grantValid) begin
      rrLast_d    = grantIdx;
      heldA_d     = req_dataa[grantIdx];
      heldB_d     = req_datab[grantIdx];
      tagIn.valid = 1'b1;
      tagIn.id    = grantIdx;
    end
  end

  assign req_ready = grant;
  assign mul_dataa = heldA_d;
  assign mul_datab = heldB_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rrLast_q <= ID_W'(NUM_REQ - 1);
      heldA_q  <= '0;
      heldB_q  <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rrLast_q <= rrLast_d;
      heldA_q  <= heldA_d;
      heldB_q  <= heldB_d;
      tag_q[0] <= tagIn;
      for (int s = 1; s < DEPTH; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // The last stage carries the tag that matches mul_result this cycle; the bus reads zero otherwise.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = tag_q[DEPTH-1].valid && (tag_q[DEPTH-1].id == ID_W'(i));
    end
    resp_data = tag_q[DEPTH-1].valid ? mul_result : '0;
    busy = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      busy = busy | tag_q[s].valid;
    end
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one fp_mul pipeline (fixed latency 6, no stall, one issue per cycle) among NUM_REQ requesters, e.g. the shader lanes of a core.
- Round-robin arbitration issues at most one operand pair per cycle into the multiplier.
- A tag pipeline, aligned to the multiplier latency, routes each result back to the requester that issued it.
- Sits between the lane operand collectors and the fp_mul instance; the multiplier's ports connect directly to mul_dataa/mul_datab/mul_result.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- MUL_LATENCY, 6: cycles from the fp_mul input sampling edge to result valid; must match the attached fp_mul.
- ID_W, $clog2(NUM_REQ): requester index width.

Ports:
- clock  in  1: single clock; all state on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  NUM_REQ: requester i has an operand pair.
- req_dataa  in  NUM_REQ×32: operand A per requester, IEEE-754 single.
- req_datab  in  NUM_REQ×32: operand B per requester.
- req_ready  out  NUM_REQ: one-hot grant; handshake on valid&ready.
- mul_dataa  out  32: to fp_mul dataa.
- mul_datab  out  32: to fp_mul datab.
- mul_result  in  32: from fp_mul result.
- resp_valid  out  NUM_REQ: one-hot; result for requester i this cycle.
- resp_data  out  32: shared result bus.
- busy  out  1: at least one transaction in flight.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - rr_last = NUM_REQ-1, so requester 0 has first priority.
  - All tag-pipeline valid bits clear.
  - resp_valid = 0, resp_data = 0, busy = 0.
  - req_ready is combinational and therefore 0 while no req_valid is high.
- Arbitration (combinational):
  - Scan from index rr_last+1 upward, wrapping modulo NUM_REQ; the first set req_valid wins.
  - req_ready = one-hot of the winner; all zero if no request.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Issue:
  - mul_dataa/mul_datab = winner's operands, combinationally, so fp_mul samples them on the handshake edge k.
  - With no winner, mul_dataa/mul_datab hold their last issued value. Garbage results are never flagged valid.
  - On edge k, rr_last ← winner index, and {1, winner id} enters the tag pipeline.
  - With no winner, a bubble {0, x} enters instead; rr_last is unchanged.
- Throughput: one issue per cycle, sustained; no backpressure from the multiplier.
- Response timing:
  - resp_valid[id] is high for exactly the one cycle after edge k+MUL_LATENCY.
  - In that same cycle resp_data = mul_result.
  - Requesters must accept responses unconditionally; there is no resp_ready.
- Tag pipeline alignment: the pipeline is sized and registered so that stage alignment matches the rule above exactly. For MUL_LATENCY=6 this is a 7-cycle issue-to-visible latency measured from the accept cycle.
- resp_data:
  - Equals mul_result when any resp_valid is set.
  - Otherwise it is driven to 0; there is no X propagation on the bus.
- busy = OR of all tag-pipeline valid bits.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ cycles.
- Boundary cases:
  - Simultaneous issue and response: independent; both occur in the same cycle.
  - Same requester issuing back-to-back while others are idle: allowed; it is granted every cycle.
  - rr_last wrap: NUM_REQ-1 → 0.
  - Non-power-of-2 NUM_REQ: indices ≥ NUM_REQ are never granted.
- Reset mid-operation:
  - All in-flight tags are discarded; no resp_valid follows reset.
  - The multiplier's internal shift registers are not reset. Their stale outputs are masked by the cleared tags.

Decomposition:
- Package fp_mul_arb_pkg: FP_W=32 constant and the typedef tag_t {logic valid; logic [ID_W-1:0] id}. ID_W is parameter-dependent, so the tag is declared as a parameterized struct inside the module; the package holds FP_W only.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and last-grant index; outputs one-hot grant and grant index. It is reused by later shared-unit arbiters (fp_add, fp_div).

Test Plan:
- Single request:
  - Stimulus: req0 with a=0x40000000 (2.0), b=0x40400000 (3.0).
  - Expected: req_ready[0] in the same cycle; resp_valid=0001 and resp_data=0x40C00000 exactly MUL_LATENCY+1 cycles after the accept cycle; busy high throughout the interval.
- Simultaneous requests:
  - Stimulus: all 4 requesters valid after reset, each with a=0x3FC00000 (1.5), b=0x40000000.
  - Expected: grants 0,1,2,3 on consecutive cycles; responses 0x40400000 on resp_valid 0001,0010,0100,1000 in the same order, on consecutive cycles.
- Round-robin wrap:
  - Stimulus: requests 3 then 0 and 3 together.
  - Expected: after granting 3, requester 0 wins over 3.
- Full throughput:
  - Stimulus: req2 continuously valid for 20 cycles with distinct operands.
  - Expected: 20 grants, 20 responses in issue order with correct products, no gaps.
- Reset mid-flight:
  - Stimulus: issue 3 transactions, assert rst_n low 2 cycles later for 1 cycle.
  - Expected: outputs at reset values immediately; no resp_valid for 10 cycles; busy=0.
- Fairness under load:
  - Stimulus: all requesters valid for 100 cycles, random drop of req_valid.
  - Expected: no requester waits >NUM_REQ cycles; each response id matches its issuer (scoreboard).
